level_sequencer: RTL



---
 rtl/level_sequencer.sv | 132 +++++++++++++
 1 files changed

// File: rtl/level_sequencer.sv
// Game-level controller: walks the player from the menu through NUM_LEVELS timed levels.
// It also tracks lives, a post-hit grace window and pause, and drives the win/lose screens.
module level_sequencer #(
  parameter int NUM_LEVELS  = 4,
  parameter int LEVEL_TICKS = 100,
  parameter int LIVES       = 3,
  parameter int GRACE_TICKS = 20,
  parameter int LVL_W       = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tick,
  input  logic                  hit,
  input  logic                  user_sel,
  input  logic                  pause,
  output logic [NUM_LEVELS-1:0] level_onehot,
  output logic [LVL_W-1:0]      level_idx,
  output logic [3:0]            lives_left,
  output logic                  level_start,
  output logic                  menu_screen,
  output logic                  win_screen,
  output logic                  lose_screen,
  output logic                  grace
);

  typedef enum logic [1:0] {S_MENU, S_PLAY, S_WIN, S_LOSE} state_t;

  localparam logic [10:0]      TIMER_LAST = 11'(LEVEL_TICKS - 1);
  localparam logic [10:0]      GRACE_LOAD = 11'(GRACE_TICKS);
  localparam logic [3:0]       LIVES_INIT = 4'(LIVES);
  localparam logic [LVL_W-1:0] LVL_LAST   = LVL_W'(NUM_LEVELS - 1);

  state_t           state_q, state_d;
  logic [LVL_W-1:0] level_idx_q, level_idx_d;
  logic [3:0]       lives_q, lives_d;
  logic [10:0]      timer_q, timer_d;
  logic [10:0]      grace_cnt_q, grace_cnt_d;
  logic             level_start_q, level_start_d;
  logic             user_sel_q;
  logic             sel_rise;

  assign sel_rise = user_sel & ~user_sel_q;

  always_comb begin
    state_d       = state_q;
    level_idx_d   = level_idx_q;
    lives_d       = lives_q;
    timer_d       = timer_q;
    grace_cnt_d   = grace_cnt_q;
    level_start_d = 1'b0;
    case (state_q)
      S_MENU: begin
        if (sel_rise) begin
          state_d       = S_PLAY;
          level_idx_d   = '0;
          lives_d       = LIVES_INIT;
          timer_d       = '0;
          grace_cnt_d   = '0;
          level_start_d = 1'b1;
        end
      end
      S_PLAY: begin
        // A hit outranks a level completion landing on the same tick.
        if (!pause) begin
          if (hit && (grace_cnt_q == '0)) begin
            if (lives_q == 4'd1) begin
              lives_d = '0;
              state_d = S_LOSE;
            end else begin
              lives_d       = lives_q - 4'd1;
              timer_d       = '0;
              grace_cnt_d   = GRACE_LOAD;
              level_start_d = 1'b1;
            end
          end else if (tick) begin
            timer_d = timer_q + 11'd1;
            if (grace_cnt_q != '0) grace_cnt_d = grace_cnt_q - 11'd1;
            if (timer_q == TIMER_LAST) begin
              if (level_idx_q == LVL_LAST) begin
                state_d = S_WIN;
              end else begin
                level_idx_d   = level_idx_q + LVL_W'(1);
                timer_d       = '0;
                level_start_d = 1'b1;
              end
            end
          end
        end
      end
      S_WIN, S_LOSE: begin
        if (sel_rise) state_d = S_MENU;
      end
      default: state_d = S_MENU;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_MENU;
      level_idx_q   <= '0;
      lives_q       <= LIVES_INIT;
      timer_q       <= '0;
      grace_cnt_q   <= '0;
      level_start_q <= 1'b0;
      user_sel_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      level_idx_q   <= level_idx_d;
      lives_q       <= lives_d;
      timer_q       <= timer_d;
      grace_cnt_q   <= grace_cnt_d;
      level_start_q <= level_start_d;
      user_sel_q    <= user_sel;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LEVELS; gi++) begin : g_onehot
      assign level_onehot[gi] = (state_q == S_PLAY) && (level_idx_q == LVL_W'(gi));
    end
  endgenerate

  assign level_idx   = level_idx_q;
  assign lives_left  = lives_q;
  assign level_start = level_start_q;
  assign menu_screen = (state_q == S_MENU);
  assign win_screen  = (state_q == S_WIN);
  assign lose_screen = (state_q == S_LOSE);
  assign grace       = (state_q == S_PLAY) && (grace_cnt_q != '0);

endmodule
